poly_eval_seq: RTL and testbench



---
 rtl/poly_eval_seq.sv | 166 ++++++++++++++++
 tb/tb_poly_eval_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_seq.sv
// poly_eval_seq: sequential Horner-rule polynomial evaluator.
// Computes p(x) = c[N]*x^N + ... + c[1]*x + c[0] using one multiply-accumulate per clock.
// Arithmetic is signed two's complement. Each step either saturates or wraps to RW bits.
// A sticky flag records whether any step of the current evaluation left the RW range.
// ready/valid handshakes on both sides; coefficients and x are captured at accept.

module poly_eval_seq #(
   parameter int XW       = 8,
   parameter int CW       = 16,
   parameter int RW       = 16,
   parameter int DEGREE   = 2,
   parameter int SATURATE = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic signed [XW-1:0]      x,
   input  logic [(DEGREE+1)*CW-1:0]  coeffs,
   input  logic                      out_ready,
   output logic                      ready,
   output logic                      valid,
   output logic signed [RW-1:0]      result,
   output logic                      overflow
);

   // Index width is at least one bit, so that DEGREE=0 still has a legal counter.
   localparam int IW        = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
   // The coefficient store is padded to a power of two, so any idx value selects a defined slot.
   localparam int NSLOT     = 1 << IW;
   // This is full-precision width for acc*x + c. No intermediate result can overflow it.
   localparam int PW        = RW + XW + 1;
   localparam int IDX_START = (DEGREE > 0) ? DEGREE - 1 : 0;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t                state;
   state_t                state_next;

   logic signed [RW-1:0]  acc;
   logic signed [XW-1:0]  xr;
   logic [IW-1:0]         idx;
   logic                  ovf_r;
   logic signed [CW-1:0]  coef_in [NSLOT];
   logic signed [CW-1:0]  coef_r  [NSLOT];

   logic                  accept;
   logic signed [PW-1:0]  acc_ext;
   logic signed [PW-1:0]  x_ext;
   logic signed [PW-1:0]  c_ext;
   logic signed [PW-1:0]  prod;
   logic signed [PW-1:0]  s;
   logic                  s_in_range;
   logic signed [RW-1:0]  s_fit;

   // Split the packed coefficient bus into slots. Any padding slots are tied to zero.
   generate
      for (genvar g = 0; g < NSLOT; g++) begin : g_coef
         if (g <= DEGREE) begin : g_used
            assign coef_in[g] = coeffs[g*CW +: CW];
         end else begin : g_pad
            assign coef_in[g] = '0;
         end
      end
   endgenerate

   // A request is taken only while idle. When reset is also high, the datapath reset takes priority.
   assign accept = start && (state == IDLE);

   // One Horner step at full precision, followed by the range check and the fit back into RW bits.
   always_comb begin
      acc_ext    = PW'(acc);
      x_ext      = PW'(xr);
      c_ext      = PW'(coef_r[idx]);
      prod       = acc_ext * x_ext;
      s          = prod + c_ext;
      s_in_range = (&s[PW-1:RW-1]) | ~(|s[PW-1:RW-1]);
      s_fit      = s[RW-1:0];
      if (!s_in_range && (SATURATE != 0)) begin
         if (s[PW-1]) begin
            s_fit = {1'b1, {(RW-1){1'b0}}};
         end else begin
            s_fit = {1'b0, {(RW-1){1'b1}}};
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: idle -> busy for DEGREE steps -> done until downstream takes the result.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (DEGREE == 0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (idx == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode. ready is forced low while reset is asserted.
   always_comb begin
      ready = 1'b0;
      valid = 1'b0;
      case (state)
         IDLE:    ready = !reset;
         DONE:    valid = 1'b1;
         default: ;
      endcase
   end

   // Accumulator, sticky overflow flag, and step counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         ovf_r <= 1'b0;
         idx   <= '0;
      end else if (accept) begin
         acc   <= RW'(coef_in[DEGREE]);
         ovf_r <= 1'b0;
         idx   <= IW'(IDX_START);
      end else if (state == BUSY) begin
         acc <= s_fit;
         if (!s_in_range) begin
            ovf_r <= 1'b1;
         end
         if (idx != '0) begin
            idx <= idx - 1'b1;
         end
      end
   end

   // Operand capture at accept. Later changes on the inputs do not affect the running evaluation.
   always_ff @(posedge clock) begin
      if (accept && !reset) begin
         xr     <= x;
         coef_r <= coef_in;
      end
   end

   assign result   = acc;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_poly_eval_seq.sv
// tb_poly_eval_seq: directed self-checking bench for poly_eval_seq.
// Four instances cover the default saturating configuration, wrapping mode, DEGREE=0 and DEGREE=4.

module tb_poly_eval_seq;

   logic clock = 1'b0;
   logic reset;

   // The default instance: DEGREE=2, saturating.
   logic               start_a;
   logic signed [7:0]  x_a;
   logic [47:0]        coeffs_a;
   logic               out_ready_a;
   logic               ready_a;
   logic               valid_a;
   logic signed [15:0] result_a;
   logic               overflow_a;

   // The wrapping instance.
   logic               start_w;
   logic signed [7:0]  x_w;
   logic [47:0]        coeffs_w;
   logic               out_ready_w;
   logic               ready_w;
   logic               valid_w;
   logic signed [15:0] result_w;
   logic               overflow_w;

   // The DEGREE=0 instance.
   logic               start_z;
   logic signed [7:0]  x_z;
   logic [15:0]        coeffs_z;
   logic               out_ready_z;
   logic               ready_z;
   logic               valid_z;
   logic signed [15:0] result_z;
   logic               overflow_z;

   // The DEGREE=4 instance.
   logic               start_f;
   logic signed [7:0]  x_f;
   logic [79:0]        coeffs_f;
   logic               out_ready_f;
   logic               ready_f;
   logic               valid_f;
   logic signed [15:0] result_f;
   logic               overflow_f;

   int checks   = 0;
   int failures = 0;
   int cyc;

   always #5 clock = ~clock;

   poly_eval_seq #(.XW(8), .CW(16), .RW(16), .DEGREE(2), .SATURATE(1)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .x(x_a), .coeffs(coeffs_a),
      .out_ready(out_ready_a), .ready(ready_a), .valid(valid_a), .result(result_a),
      .overflow(overflow_a)
   );

   poly_eval_seq #(.XW(8), .CW(16), .RW(16), .DEGREE(2), .SATURATE(0)) dut_w (
      .clock(clock), .reset(reset), .start(start_w), .x(x_w), .coeffs(coeffs_w),
      .out_ready(out_ready_w), .ready(ready_w), .valid(valid_w), .result(result_w),
      .overflow(overflow_w)
   );

   poly_eval_seq #(.XW(8), .CW(16), .RW(16), .DEGREE(0), .SATURATE(1)) dut_z (
      .clock(clock), .reset(reset), .start(start_z), .x(x_z), .coeffs(coeffs_z),
      .out_ready(out_ready_z), .ready(ready_z), .valid(valid_z), .result(result_z),
      .overflow(overflow_z)
   );

   poly_eval_seq #(.XW(8), .CW(16), .RW(16), .DEGREE(4), .SATURATE(1)) dut_f (
      .clock(clock), .reset(reset), .start(start_f), .x(x_f), .coeffs(coeffs_f),
      .out_ready(out_ready_f), .ready(ready_f), .valid(valid_f), .result(result_f),
      .overflow(overflow_f)
   );

   // Single comparison point: it counts the check and reports any failure.
   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Start an evaluation on the default instance. Call this on a falling edge; it returns just after the accept edge.
   task automatic applyStimulus(input logic signed [7:0] xv, input logic signed [15:0] c2,
                                input logic signed [15:0] c1, input logic signed [15:0] c0);
      x_a      = xv;
      coeffs_a = {c2, c1, c0};
      start_a  = 1'b1;
      @(posedge clock);
      #1 start_a = 1'b0;
   endtask

   function automatic logic validOf(input int which);
      case (which)
         0:       return valid_a;
         1:       return valid_w;
         2:       return valid_z;
         default: return valid_f;
      endcase
   endfunction

   // Count falling edges after the accept until valid is seen. A timeout returns -1.
   task automatic waitValid(input int which, input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!validOf(which) && cycles < limit);
      if (!validOf(which)) cycles = -1;
   endtask

   // Complete the output handshake on the default instance, then confirm it is idle again.
   task automatic completeA(input string tag);
      out_ready_a = 1'b1;
      @(posedge clock);
      #1 out_ready_a = 1'b0;
      @(negedge clock);
      checkOutput({tag, "_ready_after_hs"}, ready_a, 1);
      checkOutput({tag, "_valid_after_hs"}, valid_a, 0);
   endtask

   initial begin
      reset       = 1'b1;
      start_a     = 1'b0; x_a = '0; coeffs_a = '0; out_ready_a = 1'b0;
      start_w     = 1'b0; x_w = '0; coeffs_w = '0; out_ready_w = 1'b1;
      start_z     = 1'b0; x_z = '0; coeffs_z = '0; out_ready_z = 1'b1;
      start_f     = 1'b0; x_f = '0; coeffs_f = '0; out_ready_f = 1'b1;

      // Reset state
      @(negedge clock);
      checkOutput("ready_in_reset", ready_a, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_ready", ready_a, 1);
      checkOutput("reset_valid", valid_a, 0);
      checkOutput("reset_result", result_a, 0);
      checkOutput("reset_overflow", overflow_a, 0);

      // Basic case: 2*3^2 - 5*3 + 7 = 10. Accumulator goes 2 -> 1 -> 10.
      applyStimulus(8'sd3, 16'sd2, -16'sd5, 16'sd7);
      checkOutput("basic_ready_busy", ready_a, 0);
      @(negedge clock);
      checkOutput("basic_acc1", result_a, 2);
      checkOutput("basic_valid1", valid_a, 0);
      @(negedge clock);
      checkOutput("basic_acc2", result_a, 1);
      checkOutput("basic_valid2", valid_a, 0);
      @(negedge clock);
      checkOutput("basic_valid3", valid_a, 1);
      checkOutput("basic_result", result_a, 10);
      checkOutput("basic_overflow", overflow_a, 0);
      checkOutput("basic_ready_done", ready_a, 0);
      completeA("basic");

      // Negative x: (-4)^2 = 16
      applyStimulus(-8'sd4, 16'sd1, 16'sd0, 16'sd0);
      waitValid(0, 10, cyc);
      checkOutput("negx_latency", cyc, 3);
      checkOutput("negx_result", result_a, 16);
      completeA("negx");

      // Most negative x: 0*x^2 + 1*x + 0 = -128 (8'sh80 is -128).
      applyStimulus(8'sh80, 16'sd0, 16'sd1, 16'sd0);
      waitValid(0, 10, cyc);
      checkOutput("minx_result", result_a, -128);
      checkOutput("minx_overflow", overflow_a, 0);
      completeA("minx");

      // Saturating overflow: 100 -> 12700 -> 1612900, which clamps to 32767.
      applyStimulus(8'sd127, 16'sd100, 16'sd0, 16'sd0);
      @(negedge clock);
      checkOutput("sat_acc1", result_a, 100);
      @(negedge clock);
      checkOutput("sat_acc2", result_a, 12700);
      checkOutput("sat_ovf_step1", overflow_a, 0);
      @(negedge clock);
      checkOutput("sat_valid", valid_a, 1);
      checkOutput("sat_result", result_a, 32767);
      checkOutput("sat_overflow", overflow_a, 1);
      completeA("sat");

      // Wrapping overflow: 1612900 mod 2^16 = 40036, which reads as -25500 when signed.
      x_w      = 8'sd127;
      coeffs_w = {16'sd100, 16'sd0, 16'sd0};
      start_w  = 1'b1;
      @(posedge clock);
      #1 start_w = 1'b0;
      waitValid(1, 10, cyc);
      checkOutput("wrap_latency", cyc, 3);
      checkOutput("wrap_result", result_w, -25500);
      checkOutput("wrap_overflow", overflow_w, 1);

      // A clean evaluation afterwards clears the sticky flag.
      @(negedge clock);
      applyStimulus(8'sd3, 16'sd2, -16'sd5, 16'sd7);
      waitValid(0, 10, cyc);
      checkOutput("clean_result", result_a, 10);
      checkOutput("clean_overflow", overflow_a, 0);
      completeA("clean");

      // Back-pressure, with operands changed after accept: x=2, all coefficients 1, result 7.
      applyStimulus(8'sd2, 16'sd1, 16'sd1, 16'sd1);
      x_a      = 8'sd100;
      coeffs_a = {16'sd9, 16'sd9, 16'sd9};
      waitValid(0, 10, cyc);
      checkOutput("bp_latency", cyc, 3);
      checkOutput("bp_result", result_a, 7);
      for (int i = 0; i < 5; i++) begin
         start_a = 1'b1;
         @(negedge clock);
         checkOutput($sformatf("bp_hold_result_%0d", i), result_a, 7);
         checkOutput($sformatf("bp_hold_valid_%0d", i), valid_a, 1);
         checkOutput($sformatf("bp_hold_ready_%0d", i), ready_a, 0);
      end
      start_a = 1'b0;
      completeA("bp");
      checkOutput("bp_result_kept", result_a, 7);

      // Reset one cycle after accept abandons the evaluation.
      applyStimulus(8'sd3, 16'sd2, -16'sd5, 16'sd7);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_mid_result", result_a, 0);
      checkOutput("rst_mid_ready", ready_a, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rst_mid_no_valid_%0d", i), valid_a, 0);
         @(negedge clock);
      end
      applyStimulus(8'sd3, 16'sd2, -16'sd5, 16'sd7);
      waitValid(0, 10, cyc);
      checkOutput("rst_fresh_latency", cyc, 3);
      checkOutput("rst_fresh_result", result_a, 10);
      completeA("rst_fresh");

      // DEGREE=0: the result is c0 and becomes valid one cycle after accept.
      x_z      = 8'sd5;
      coeffs_z = -16'sd9;
      start_z  = 1'b1;
      @(posedge clock);
      #1 start_z = 1'b0;
      waitValid(2, 10, cyc);
      checkOutput("deg0_latency", cyc, 1);
      checkOutput("deg0_result", result_z, -9);
      checkOutput("deg0_overflow", overflow_z, 0);

      // DEGREE=4 with x=2 and all coefficients 1: the accumulator goes 1 -> 3 -> 7 -> 15 -> 31.
      x_f      = 8'sd2;
      coeffs_f = {16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
      start_f  = 1'b1;
      @(posedge clock);
      #1 start_f = 1'b0;
      waitValid(3, 12, cyc);
      checkOutput("deg4_latency", cyc, 5);
      checkOutput("deg4_result", result_f, 31);
      checkOutput("deg4_overflow", overflow_f, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
